iomem_arbiter: RTL
==================

IOMEM_ARBITER -- requirements
Module: iomem_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255: slave cycles allowed before abort (1..255).
REQ-002 The block SHALL have parameter ERR_RDATA, default 32'hDEAD_BEEF: read data returned on timeout.
REQ-003 The block SHALL have these ports (one clock; reset is synchronous and active-low):
- clk  in  1  sole clock, all state on posedge
- resetn  in  1  synchronous, active-low reset
- m0_valid / m1_valid  in  1  master request, held until its ready
- m0_addr / m1_addr  in  32  byte address
- m0_wdata / m1_wdata  in  32  write data
- m0_wstrb / m1_wstrb  in  4  byte strobes; 0 = read
- m0_ready / m1_ready  out  1  one-cycle completion pulse
- m0_rdata / m1_rdata  out  32  read data, valid while ready=1
- s_valid  out  1  request to shared slave
- s_addr, s_wdata, s_wstrb  out  32/32/4  granted master's request
- s_ready  in  1  slave completion
- s_rdata  in  32  slave read data
- grant  out  2  one-hot owner; 0 when idle
- timeout_err  out  1  one-cycle pulse on abort
- err_count  out  8  saturating timeout count

Function
REQ-004 States SHALL be IDLE, BUSY, RESP.
REQ-005 In IDLE: s_valid=0, grant=0, no ready; the block SHALL go to BUSY on any mX_valid, with the grant registered.
REQ-006 Tie (both valid in IDLE): grant SHALL go to the master not served last; last_served SHALL reset to m1, so m0 wins the first tie.
REQ-007 Single requester SHALL be granted regardless of last_served.
REQ-008 In BUSY: s_valid=1 and s_addr/s_wdata/s_wstrb SHALL pass through combinationally from the granted master.
REQ-009 Ungranted master: s_* SHALL be unaffected, ready=0, and its request SHALL be held pending.
REQ-010 BUSY with s_ready=1: the block SHALL capture s_rdata, update last_served and go to RESP.
REQ-011 In RESP: s_valid=0; the granted master's ready=1 for exactly one cycle with the captured rdata; then the block SHALL go to IDLE.
REQ-012 Minimum transaction SHALL take 4 cycles from valid to return to IDLE: IDLE sample, BUSY (s_ready same cycle), RESP, IDLE.
REQ-013 Timeout: a watchdog counter SHALL clear on entry to BUSY and increment each BUSY cycle with s_ready=0. When it reaches TIMEOUT_CYCLES, the block SHALL go to RESP with rdata=ERR_RDATA, pulse timeout_err in that RESP cycle, and increment err_count, saturating at 255.
REQ-014 s_ready and the timeout in the same cycle: s_ready SHALL win, with no error.
REQ-015 s_ready in IDLE or RESP SHALL be ignored.
REQ-016 mX_rdata SHALL be 0 whenever mX_ready=0.
REQ-017 A granted master dropping valid in BUSY (protocol violation) SHALL NOT cancel the transaction; the block SHALL complete normally.
REQ-018 Back-to-back: a master may reassert valid in the IDLE cycle after RESP; round-robin SHALL still apply.

Reset
REQ-019 resetn=0 at a clock edge SHALL force: state=IDLE, grant=0, s_valid=0, m0/m1_ready=0, m0/m1_rdata=0, timeout_err=0, err_count=0, watchdog=0, last_served=m1.
REQ-020 Reset mid-BUSY or mid-RESP SHALL abort the transaction with no ready pulse to any master.

Structure
REQ-021 A shared package SHALL hold the state enum (IDLE/BUSY/RESP), the ERR_RDATA default and the grant encodings.
REQ-022 The watchdog counter plus timeout compare SHALL be a single sub-module, iomem_watchdog (inputs clr, en, limit; output expired).

Verification
REQ-023 m0 reads 0x0500_0010, slave ready 3 cycles after s_valid with 0x1234_5678 -> m0_ready one cycle, m0_rdata=0x1234_5678, m1_ready=0, grant=01.
REQ-024 Both valid in the same cycle after reset -> m0 served first, then m1 (grant 01 then 10). Repeat with both valid -> m0 next; continuous contention alternates strictly.
REQ-025 m1 write 0xCAFE_0001, wstrb 4'b0011, slave never ready -> after 255 BUSY cycles: m1_ready=1, m1_rdata=0xDEAD_BEEF, timeout_err pulse, err_count=1.
REQ-026 Stall 300 transactions -> err_count saturates at 255. s_ready coincident with the timeout cycle -> normal data, no error.
REQ-027 resetn=0 during BUSY (cycle 2 of a stalled read) -> next cycle s_valid=0, grant=0, no ready pulse; a fresh request then completes normally.
REQ-028 s_ready pulsed while IDLE with no request -> no ready output and no state change.

Source files
------------

// File: rtl/iomem_arbiter_pkg.sv
// Shared definitions for the two-master memory arbiter: FSM states,
// grant encodings, the timeout read-data default and a saturating helper.
package iomem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

    localparam int unsigned WD_W = 8;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/iomem_watchdog.sv
// Slave-stall watchdog: counts stalled BUSY cycles and flags the cycle in
// which the count would reach the limit, so the caller can abort right then.
module iomem_watchdog
    import iomem_arbiter_pkg::*;
(
    input  logic            clk,
    input  logic            resetn,
    input  logic            clr,
    input  logic            en,
    input  logic [WD_W-1:0] limit,
    output logic            expired
);

    logic [WD_W-1:0] cnt_q;
    logic [WD_W-1:0] cnt_d;

    // Next count: clear wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires in the stalled cycle whose increment reaches the limit; the
    // counter never runs past the limit because the arbiter leaves BUSY.
    assign expired = en && !clr && ((cnt_q + 8'd1) == limit);

endmodule

// File: rtl/iomem_arbiter.sv
// Round-robin arbiter giving two masters access to one shared slave, with a
// stall watchdog that aborts a hung transaction and returns ERR_RDATA.
module iomem_arbiter
    import iomem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant,
    output logic        timeout_err,
    output logic [7:0]  err_count
);

    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

    state_e      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic        last_m1_q, last_m1_d;   // 1 when m1 was the last master served
    logic [31:0] rdata_q, rdata_d;
    logic        terr_q, terr_d;         // current RESP is a timeout abort
    logic [7:0]  err_count_q, err_count_d;

    logic        wd_clr;
    logic        wd_en;
    logic        wd_expired;

    iomem_watchdog u_watchdog (
        .clk     (clk),
        .resetn  (resetn),
        .clr     (wd_clr),
        .en      (wd_en),
        .limit   (WD_LIMIT),
        .expired (wd_expired)
    );

    // Next-state and output decode; every output defaults to its idle value.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_m1_d   = last_m1_q;
        rdata_d     = rdata_q;
        terr_d      = terr_q;
        err_count_d = err_count_q;
        wd_clr      = 1'b0;
        wd_en       = 1'b0;
        s_valid     = 1'b0;
        s_addr      = '0;
        s_wdata     = '0;
        s_wstrb     = '0;
        m0_ready    = 1'b0;
        m1_ready    = 1'b0;
        m0_rdata    = '0;
        m1_rdata    = '0;
        timeout_err = 1'b0;

        case (state_q)
            IDLE: begin
                if (m0_valid || m1_valid) begin
                    state_d = BUSY;
                    wd_clr  = 1'b1;
                    if (m0_valid && m1_valid) begin
                        grant_d = last_m1_q ? GRANT_M0 : GRANT_M1;
                    end else if (m0_valid) begin
                        grant_d = GRANT_M0;
                    end else begin
                        grant_d = GRANT_M1;
                    end
                end
            end

            BUSY: begin
                // The request is taken from the master's live inputs, so a
                // master that drops valid here still completes normally.
                s_valid = 1'b1;
                if (grant_q == GRANT_M1) begin
                    s_addr  = m1_addr;
                    s_wdata = m1_wdata;
                    s_wstrb = m1_wstrb;
                end else begin
                    s_addr  = m0_addr;
                    s_wdata = m0_wdata;
                    s_wstrb = m0_wstrb;
                end
                wd_en = !s_ready;
                if (s_ready) begin
                    rdata_d   = s_rdata;
                    terr_d    = 1'b0;
                    last_m1_d = (grant_q == GRANT_M1);
                    state_d   = RESP;
                end else if (wd_expired) begin
                    rdata_d     = ERR_RDATA;
                    terr_d      = 1'b1;
                    err_count_d = sat_inc8(err_count_q);
                    last_m1_d   = (grant_q == GRANT_M1);
                    state_d     = RESP;
                end
            end

            RESP: begin
                m0_ready    = grant_q[0];
                m1_ready    = grant_q[1];
                m0_rdata    = grant_q[0] ? rdata_q : 32'd0;
                m1_rdata    = grant_q[1] ? rdata_q : 32'd0;
                timeout_err = terr_q;
                state_d     = IDLE;
                grant_d     = GRANT_NONE;
                terr_d      = 1'b0;
            end

            default: begin
                state_d = IDLE;
                grant_d = GRANT_NONE;
            end
        endcase
    end

    // Control state; reset aborts any transaction without a ready pulse.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            grant_q     <= GRANT_NONE;
            last_m1_q   <= 1'b1;
            terr_q      <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_m1_q   <= last_m1_d;
            terr_q      <= terr_d;
            err_count_q <= err_count_d;
        end
    end

    // Response data holding register; only observed while a ready is driven.
    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
    end

    assign grant     = grant_q;
    assign err_count = err_count_q;

endmodule
